fir_result_checker: RTL and testbench

//  Synthesizable sink-side checker for the 3-tap fir_filter. It watches the sample stream
//  fed into fir_filter and the fir_out it returns, and rebuilds the expected output from its
//  own sample delay line. It then compares every checked result and reports pass/fail, an

---
 rtl/fir_result_checker.sv | 137 +++++++++++++
 tb/tb_fir_result_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fir_result_checker.sv
// Sink-side checker for the 3-tap fir_filter: rebuilds each expected result from its own
// delay line and compares it with fir_out. Optional: FIR_CHK_STOP_ON_ERR_EN ends a run on the first mismatch.
module fir_result_checker #(
    parameter int width   = 8,
    parameter int DUT_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     chk_len,
    input  logic                 sample_vld,
    input  logic [width-1:0]     fir_in,
    input  logic [width-1:0]     w_1,
    input  logic [width-1:0]     w_2,
    input  logic [width-1:0]     w_3,
    input  logic [2*width-1:0]   fir_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     first_idx,
    output logic [2*width-1:0]   first_exp,
    output logic [2*width-1:0]   first_got
);

    localparam int RW = 2 * width;

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;
    state_t state, state_nx;

    logic [width-1:0]   c1, c2, c3;
    logic [width-1:0]   x0, x1;
    logic [CNT_W-1:0]   len, cmp_cnt;
    logic               fill_one;
    logic [RW-1:0]      exp_in;
    logic [RW-1:0]      exp_p [DUT_LAT];
    logic [DUT_LAT-1:0] vld_p;
    logic               start_ok, cmp, mism, last;

    assign start_ok = start && (state == IDLE || state == DONE);

    // The incoming sample is the newest tap, so x0/x1 hold the two older ones here.
    assign exp_in = RW'(c1) * RW'(fir_in) + RW'(c2) * RW'(x0) + RW'(c3) * RW'(x1);

    assign cmp  = vld_p[DUT_LAT-1] && (state == CHECK);
    assign mism = cmp && (fir_out != exp_p[DUT_LAT-1]);
    assign last = cmp && ((cmp_cnt + CNT_W'(1)) == len);

    assign busy = (state == FILL) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

    // Sample delay line and expected-value pipe aligned to the filter latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x0    <= '0;
            x1    <= '0;
            vld_p <= '0;
            for (int i = 0; i < DUT_LAT; i++) exp_p[i] <= '0;
        end else begin
            if (sample_vld) begin
                x0 <= fir_in;
                x1 <= x0;
            end
            exp_p[0] <= exp_in;
            vld_p[0] <= sample_vld && (state == CHECK);
            for (int i = 1; i < DUT_LAT; i++) begin
                exp_p[i] <= exp_p[i-1];
                vld_p[i] <= vld_p[i-1];
            end
            // Tags left over from a previous run must never be compared in the next one.
            if (start_ok) vld_p <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            c1        <= '0;
            c2        <= '0;
            c3        <= '0;
            len       <= '0;
            cmp_cnt   <= '0;
            fill_one  <= 1'b0;
            err_cnt   <= '0;
            first_idx <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                c1        <= w_1;
                c2        <= w_2;
                c3        <= w_3;
                len       <= chk_len;
                cmp_cnt   <= '0;
                fill_one  <= 1'b0;
                err_cnt   <= '0;
                first_idx <= '0;
                first_exp <= '0;
                first_got <= '0;
            end else begin
                if (state == FILL && sample_vld) fill_one <= 1'b1;
                if (cmp) cmp_cnt <= cmp_cnt + CNT_W'(1);
                if (mism) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
                    if (err_cnt == '0) begin
                        first_idx <= cmp_cnt;
                        first_exp <= exp_p[DUT_LAT-1];
                        first_got <= fir_out;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = FILL;
            FILL: begin
                if (len == '0)                    state_nx = DONE;
                else if (sample_vld && fill_one)  state_nx = CHECK;
            end
            CHECK: begin
`ifdef FIR_CHK_STOP_ON_ERR_EN
                if (last || mism) state_nx = DONE;
`else
                if (last) state_nx = DONE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_result_checker.sv
// Directed bench for fir_result_checker: the bench plays the filter by driving fir_out
// with hand-computed results one cycle after each sample (DUT_LAT = 1).
module tb_fir_result_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] chk_len;
    logic        sample_vld;
    logic [7:0]  fir_in, w_1, w_2, w_3;
    logic [15:0] fir_out;
    logic        busy, done, pass;
    logic [15:0] err_cnt, first_idx, first_exp, first_got;

    int n_cmp = 0;
    int n_bad = 0;

    fir_result_checker #(.width(8), .DUT_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chk_len(chk_len),
        .sample_vld(sample_vld), .fir_in(fir_in), .w_1(w_1), .w_2(w_2), .w_3(w_3),
        .fir_out(fir_out), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_idx(first_idx), .first_exp(first_exp), .first_got(first_got)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [15:0] n);
        w_1 = a; w_2 = b; w_3 = c; chk_len = n; start = 1'b1;
        tick();
        start = 1'b0;
        // Scramble inputs that must already have been captured.
        w_1 = 8'h00; w_2 = 8'h00; w_3 = 8'h00; chk_len = 16'd9;
    endtask

    task automatic send(input logic [7:0] s, input logic [15:0] o);
        fir_in = s; sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
        fir_out = o;
    endtask

    // Samples FF,00,FF,00,00 with w=5B/FF/87; the 2nd checked result can be corrupted.
    task automatic run_std(input logic [15:0] bad1, input int gap);
        logic [7:0]  samp [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic [15:0] outs [5] = '{16'h5AA5, 16'hFE01, 16'hE11E, 16'hFE01, 16'h8679};
        outs[3] = bad1;
        for (int i = 0; i < 5; i++) begin
            send(samp[i], outs[i]);
            if (gap > 0) begin
                tick();
                fir_out = 16'hDEAD;
                repeat (gap - 1) tick();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; chk_len = '0; sample_vld = 1'b0;
        fir_in = '0; w_1 = '0; w_2 = '0; w_3 = '0; fir_out = '0;
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_first_exp", first_exp, 0);
        rst_n = 1'b1;
        tick();

        // 1: clean run
        start_run(8'h5B, 8'hFF, 8'h87, 16'd3);
        check("t1_busy_fill", busy, 1);
        check("t1_done_early", done, 0);
        run_std(16'hFE01, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_err", err_cnt, 0);
        check("t1_busy_end", busy, 0);

        // 2: second checked result wrong
        start_run(8'h5B, 8'hFF, 8'h87, 16'd3);
        run_std(16'h0000, 0);
        tick();
        check("t2_done", done, 1);
        check("t2_pass", pass, 0);
        check("t2_err", err_cnt, 1);
        check("t2_idx", first_idx, 1);
        check("t2_exp", first_exp, 16'hFE01);
        check("t2_got", first_got, 16'h0000);

        // 3: wrap-around of the expected sum
        start_run(8'hFF, 8'hFF, 8'hFF, 16'd1);
        send(8'hFF, 16'hFE01);
        send(8'hFF, 16'hFC02);
        send(8'hFF, 16'hFA03);
        tick();
        check("t3_done", done, 1);
        check("t3_pass", pass, 1);
        check("t3_err", err_cnt, 0);

        start_run(8'hFF, 8'hFF, 8'hFF, 16'd1);
        send(8'hFF, 16'hFE01);
        send(8'hFF, 16'hFC02);
        send(8'hFF, 16'hFA04);
        tick();
        check("t3b_pass", pass, 0);
        check("t3b_idx", first_idx, 0);
        check("t3b_exp", first_exp, 16'hFA03);
        check("t3b_got", first_got, 16'hFA04);

        // 4: gaps between samples, plus a start pulse while busy
        start_run(8'h5B, 8'hFF, 8'h87, 16'd3);
        w_1 = 8'h00; chk_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_start_ignored", busy, 1);
        run_std(16'hFE01, 5);
        tick();
        check("t4_done", done, 1);
        check("t4_pass", pass, 1);
        check("t4_err", err_cnt, 0);

        // zero-length run
        start_run(8'h5B, 8'hFF, 8'h87, 16'd0);
        check("t0_busy", busy, 1);
        tick();
        check("t0_done", done, 1);
        check("t0_pass", pass, 1);

        // 5: reset in the middle of CHECK
        start_run(8'h5B, 8'hFF, 8'h87, 16'd3);
        send(8'hFF, 16'h5AA5);
        send(8'h00, 16'hFE01);
        send(8'hFF, 16'h0000);
        send(8'h00, 16'hFE01);
        check("t5_mid_err", err_cnt, 1);
        check("t5_mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_err", err_cnt, 0);
        check("t5_got", first_got, 0);
        start_run(8'h5B, 8'hFF, 8'h87, 16'd3);
        run_std(16'hFE01, 0);
        tick();
        check("t5_rerun_done", done, 1);
        check("t5_rerun_pass", pass, 1);

        // 6: mismatch at index 1 of a 10-result run
        start_run(8'h5B, 8'hFF, 8'h87, 16'd10);
        send(8'hFF, 16'h5AA5);
        send(8'h00, 16'hFE01);
        send(8'hFF, 16'hE11E);
        send(8'h00, 16'h0000);
        send(8'h00, 16'h8679);
        check("t6_err", err_cnt, 1);
        check("t6_idx", first_idx, 1);
`ifdef FIR_CHK_STOP_ON_ERR_EN
        check("t6_done", done, 1);
        check("t6_pass", pass, 0);
`else
        check("t6_running", busy, 1);
        check("t6_not_done", done, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
